instr_encoder_loader: RTL and testbench

- Encoder counterpart to the main control decoder.
- Accepts symbolic instruction fields (kind, registers, funct, immediate) over a valid/ready stream and encodes each into a 32-bit MIPS word using exactly the opcode set the datapath decodes: RTYPE, LW, SW, BEQ, ADDI.
- Writes the words sequentially into instruction memory through a simple write port, to load test programs before the pipeline is released from reset.

---
 rtl/instr_encoder_loader.sv | 141 ++++++++++++++
 tb/tb_instr_encoder_loader.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder_loader.sv
// Encodes symbolic MIPS instruction fields (RTYPE/LW/SW/BEQ/ADDI) and streams
// the resulting words into instruction memory through a simple write port.
module instr_encoder_loader #(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              finish,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_kind,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [5:0]        in_funct,
  input  logic [15:0]       in_imm,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam logic [ADDR_W:0] FULL_COUNT = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [1:0] {IDLE, LOAD, DONE, ERR} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic                imem_we_q, imem_we_d;
  logic [ADDR_W-1:0]   imem_addr_q, imem_addr_d;
  logic [31:0]         imem_wdata_q, imem_wdata_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                error_q, error_d;

  logic                accept;
  logic                legal;
  logic [31:0]         enc_word;

  assign in_ready = (state_q == LOAD) && (count_q < FULL_COUNT) && !start;
  assign accept   = in_valid && in_ready;

  always_comb begin
    legal    = 1'b0;
    enc_word = '0;
    case (in_kind)
      3'd0: begin
        enc_word = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, in_funct};
        case (in_funct)
          6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010: legal = 1'b1;
          default: legal = 1'b0;
        endcase
      end
      3'd1: begin
        legal    = 1'b1;
        enc_word = {6'b100011, in_rs, in_rt, in_imm};
      end
      3'd2: begin
        legal    = 1'b1;
        enc_word = {6'b101011, in_rs, in_rt, in_imm};
      end
      3'd3: begin
        legal    = 1'b1;
        enc_word = {6'b000100, in_rs, in_rt, in_imm};
      end
      3'd4: begin
        legal    = 1'b1;
        enc_word = {6'b001000, in_rs, in_rt, in_imm};
      end
      default: begin
        legal    = 1'b0;
        enc_word = '0;
      end
    endcase
  end

  // An illegal acceptance wins over a coincident finish; a legal one is still written.
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    if (start) begin
      state_d = LOAD;
      count_d = '0;
    end else if (state_q == LOAD) begin
      if (accept && !legal) begin
        state_d = ERR;
      end else begin
        if (accept) begin
          imem_we_d    = 1'b1;
          imem_addr_d  = count_q[ADDR_W-1:0];
          imem_wdata_d = enc_word;
          count_d      = count_q + 1'b1;
        end
        if (finish) begin
          state_d = DONE;
        end
      end
    end
    busy_d  = (state_d == LOAD);
    done_d  = (state_d == DONE);
    error_d = (state_d == ERR);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      count_q      <= '0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign count      = count_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Scoreboard bench for instr_encoder_loader: a 64-word instance for the main
// scenarios and a 4-word instance for the memory-full case.
module tb_instr_encoder_loader;

  localparam int S_IDLE = 0;
  localparam int S_LOAD = 1;
  localparam int S_DONE = 2;
  localparam int S_ERR  = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        start0, finish0, valid0;
  logic        start1, finish1, valid1;
  logic [2:0]  kind;
  logic [4:0]  rs, rt, rd;
  logic [5:0]  funct;
  logic [15:0] imm;

  logic        ready0, we0, busy0, done0, error0;
  logic [5:0]  addr0;
  logic [31:0] wdata0;
  logic [6:0]  count0;

  logic        ready1, we1, busy1, done1, error1;
  logic [1:0]  addr1;
  logic [31:0] wdata1;
  logic [2:0]  count1;

  int checks   = 0;
  int failures = 0;
  bit mon_en   = 1'b0;
  logic rdy;

  int m_state [2] = '{S_IDLE, S_IDLE};
  int m_count [2] = '{0, 0};
  int depth   [2] = '{64, 4};

  logic [37:0] q0 [$];
  logic [33:0] q1 [$];
  logic [37:0] e0;
  logic [33:0] e1;

  instr_encoder_loader #(.ADDR_W(6)) dut0 (
    .clk(clk), .reset(reset), .start(start0), .finish(finish0),
    .in_valid(valid0), .in_ready(ready0), .in_kind(kind), .in_rs(rs),
    .in_rt(rt), .in_rd(rd), .in_funct(funct), .in_imm(imm),
    .imem_we(we0), .imem_addr(addr0), .imem_wdata(wdata0), .count(count0),
    .busy(busy0), .done(done0), .error(error0)
  );

  instr_encoder_loader #(.ADDR_W(2)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .finish(finish1),
    .in_valid(valid1), .in_ready(ready1), .in_kind(kind), .in_rs(rs),
    .in_rt(rt), .in_rd(rd), .in_funct(funct), .in_imm(imm),
    .imem_we(we1), .imem_addr(addr1), .imem_wdata(wdata1), .count(count1),
    .busy(busy1), .done(done1), .error(error1)
  );

  // Every write must match the oldest expected entry, and no expected entry may go unwritten.
  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if (we0 !== (q0.size() != 0)) begin
        failures++;
        $display("[TB] FAIL wr_strobe0 got=%b exp=%b t=%0t", we0, (q0.size() != 0), $time);
        if (we0 !== 1'b1 && q0.size() != 0) void'(q0.pop_front());
      end else if (we0) begin
        e0 = q0.pop_front();
        checks++;
        if ({addr0, wdata0} !== e0) begin
          failures++;
          $display("[TB] FAIL wr_data0 got addr=%0d data=%h exp addr=%0d data=%h",
                   addr0, wdata0, e0[37:32], e0[31:0]);
        end
      end
      checks++;
      if (we1 !== (q1.size() != 0)) begin
        failures++;
        $display("[TB] FAIL wr_strobe1 got=%b exp=%b t=%0t", we1, (q1.size() != 0), $time);
        if (we1 !== 1'b1 && q1.size() != 0) void'(q1.pop_front());
      end else if (we1) begin
        e1 = q1.pop_front();
        checks++;
        if ({addr1, wdata1} !== e1) begin
          failures++;
          $display("[TB] FAIL wr_data1 got addr=%0d data=%h exp addr=%0d data=%h",
                   addr1, wdata1, e1[33:32], e1[31:0]);
        end
      end
    end
  end

  // Drives one clock of stimulus and advances the reference model; ends at the next negedge.
  task automatic cycle(input int u, input bit rst, input bit st, input bit fin, input bit vld,
                       input logic [2:0] k, input logic [4:0] s, input logic [4:0] t,
                       input logic [4:0] d, input logic [5:0] f, input logic [15:0] i,
                       input bit lg, input logic [31:0] w, output logic got_rdy);
    bit exp_ready;
    logic [6:0] mc;
    reset   = rst;
    kind    = k; rs = s; rt = t; rd = d; funct = f; imm = i;
    start0  = (u == 0) && st;  finish0 = (u == 0) && fin;  valid0 = (u == 0) && vld;
    start1  = (u == 1) && st;  finish1 = (u == 1) && fin;  valid1 = (u == 1) && vld;
    #1;
    got_rdy   = (u == 0) ? ready0 : ready1;
    exp_ready = (m_state[u] == S_LOAD) && (m_count[u] < depth[u]) && !st;
    @(posedge clk);
    if (rst) begin
      for (int n = 0; n < 2; n++) begin
        m_state[n] = S_IDLE;
        m_count[n] = 0;
      end
    end else if (st) begin
      m_state[u] = S_LOAD;
      m_count[u] = 0;
    end else if (m_state[u] == S_LOAD) begin
      if (vld && exp_ready) begin
        if (!lg) begin
          m_state[u] = S_ERR;
        end else begin
          mc = 7'(m_count[u]);
          if (u == 0) q0.push_back({mc[5:0], w});
          else        q1.push_back({mc[1:0], w});
          m_count[u]++;
        end
      end
      if (fin && m_state[u] == S_LOAD) m_state[u] = S_DONE;
    end
    @(negedge clk);
  endtask

  task automatic nop(input int u, input int n);
    for (int c = 0; c < n; c++) cycle(u, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, rdy);
  endtask

  task automatic do_start(input int u);
    cycle(u, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, rdy);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start0 = 0; finish0 = 0; valid0 = 0; start1 = 0; finish1 = 0; valid1 = 0;
    kind = 0; rs = 0; rt = 0; rd = 0; funct = 0; imm = 0;
    @(posedge clk);
    @(negedge clk);
    mon_en = 1'b1;
    cycle(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, rdy);
    checks++;
    if ({we0, addr0, wdata0} !== 39'd0) begin
      failures++;
      $display("[TB] FAIL reset_wport0 got we=%b addr=%0d data=%h exp all zero", we0, addr0, wdata0);
    end
    checks++;
    if ({count0, busy0, done0, error0} !== 10'd0) begin
      failures++;
      $display("[TB] FAIL reset_status0 got count=%0d busy=%b done=%b err=%b exp zeros",
               count0, busy0, done0, error0);
    end
    checks++;
    if ({we1, addr1, wdata1, count1, busy1, done1, error1} !== 41'd0) begin
      failures++;
      $display("[TB] FAIL reset_inst1 got we=%b count=%0d busy=%b exp zeros", we1, count1, busy1);
    end
    nop(0, 1);
    checks++;
    if (ready0 !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_ready got=%b exp=0", ready0);
    end
  endtask

  task automatic test_rtype();
    do_start(0);
    cycle(0, 0, 0, 0, 1, 3'd0, 5'd1, 5'd2, 5'd3, 6'b100000, 16'h0000, 1, 32'h00221820, rdy);
    checks++;
    if (rdy !== 1'b1) begin
      failures++;
      $display("[TB] FAIL rtype_ready got=%b exp=1", rdy);
    end
    checks++;
    if ({we0, addr0, count0} !== {1'b1, 6'd0, 7'd1}) begin
      failures++;
      $display("[TB] FAIL rtype_write got we=%b addr=%0d count=%0d exp we=1 addr=0 count=1",
               we0, addr0, count0);
    end
    nop(0, 1);
    checks++;
    if ({we0, wdata0} !== {1'b0, 32'h00221820}) begin
      failures++;
      $display("[TB] FAIL rtype_hold got we=%b data=%h exp we=0 data=00221820", we0, wdata0);
    end
  endtask

  task automatic test_back_to_back();
    do_start(0);
    cycle(0, 0, 0, 0, 1, 3'd1, 5'd0, 5'd2, 5'h1f, 6'h3f, 16'h0004, 1, 32'h8C020004, rdy);
    cycle(0, 0, 0, 0, 1, 3'd2, 5'd1, 5'd2, 5'd0,  6'h00, 16'h0008, 1, 32'hAC220008, rdy);
    cycle(0, 0, 0, 0, 1, 3'd3, 5'd1, 5'd2, 5'd7,  6'h01, 16'hFFFF, 1, 32'h1022FFFF, rdy);
    cycle(0, 0, 0, 1, 1, 3'd4, 5'd0, 5'd5, 5'd0,  6'h00, 16'h0007, 1, 32'h20050007, rdy);
    checks++;
    if ({we0, addr0, done0, busy0, count0} !== {1'b1, 6'd3, 1'b1, 1'b0, 7'd4}) begin
      failures++;
      $display("[TB] FAIL b2b_finish got we=%b addr=%0d done=%b busy=%b count=%0d exp 1 3 1 0 4",
               we0, addr0, done0, busy0, count0);
    end
    cycle(0, 0, 0, 1, 1, 3'd4, 5'd0, 5'd5, 5'd0, 6'h00, 16'h0009, 1, 32'h20050009, rdy);
    checks++;
    if ({rdy, done0, count0} !== {1'b0, 1'b1, 7'd4}) begin
      failures++;
      $display("[TB] FAIL done_hold got ready=%b done=%b count=%0d exp ready=0 done=1 count=4",
               rdy, done0, count0);
    end
  endtask

  task automatic test_illegal();
    do_start(0);
    cycle(0, 0, 0, 0, 1, 3'd6, 5'd1, 5'd2, 5'd3, 6'b100000, 16'h0000, 0, 32'h0, rdy);
    checks++;
    if ({error0, busy0, count0} !== {1'b1, 1'b0, 7'd0}) begin
      failures++;
      $display("[TB] FAIL illegal_kind got err=%b busy=%b count=%0d exp err=1 busy=0 count=0",
               error0, busy0, count0);
    end
    cycle(0, 0, 0, 1, 1, 3'd4, 5'd0, 5'd5, 5'd0, 6'h00, 16'h0007, 1, 32'h20050007, rdy);
    checks++;
    if ({rdy, error0, done0} !== {1'b0, 1'b1, 1'b0}) begin
      failures++;
      $display("[TB] FAIL err_sticky got ready=%b err=%b done=%b exp ready=0 err=1 done=0",
               rdy, error0, done0);
    end
    do_start(0);
    checks++;
    if ({error0, busy0, count0} !== {1'b0, 1'b1, 7'd0}) begin
      failures++;
      $display("[TB] FAIL err_clear got err=%b busy=%b count=%0d exp err=0 busy=1 count=0",
               error0, busy0, count0);
    end
    cycle(0, 0, 0, 0, 1, 3'd4, 5'd0, 5'd5, 5'd0, 6'h00, 16'h0007, 1, 32'h20050007, rdy);
    cycle(0, 0, 0, 0, 1, 3'd0, 5'd1, 5'd2, 5'd3, 6'b000001, 16'h0000, 0, 32'h0, rdy);
    checks++;
    if ({error0, count0} !== {1'b1, 7'd1}) begin
      failures++;
      $display("[TB] FAIL illegal_funct got err=%b count=%0d exp err=1 count=1", error0, count0);
    end
    do_start(0);
    cycle(0, 0, 0, 0, 1, 3'd4, 5'd0, 5'd5, 5'd0, 6'h00, 16'h0007, 1, 32'h20050007, rdy);
    checks++;
    if ({we0, addr0, count0} !== {1'b1, 6'd0, 7'd1}) begin
      failures++;
      $display("[TB] FAIL restart_addr got we=%b addr=%0d count=%0d exp we=1 addr=0 count=1",
               we0, addr0, count0);
    end
  endtask

  task automatic test_full();
    do_start(1);
    cycle(1, 0, 0, 0, 1, 3'd0, 5'd4,  5'd5,  5'd6, 6'b100010, 16'h0000, 1, 32'h00853022, rdy);
    cycle(1, 0, 0, 0, 1, 3'd0, 5'd7,  5'd8,  5'd9, 6'b100100, 16'h0000, 1, 32'h00E84824, rdy);
    cycle(1, 0, 0, 0, 1, 3'd1, 5'd3,  5'd4,  5'd0, 6'h00,     16'h0010, 1, 32'h8C640010, rdy);
    cycle(1, 0, 0, 0, 1, 3'd2, 5'd31, 5'd31, 5'd0, 6'h00,     16'hABCD, 1, 32'hAFFFABCD, rdy);
    checks++;
    if ({rdy, count1} !== {1'b1, 3'd4}) begin
      failures++;
      $display("[TB] FAIL full_fill got ready=%b count=%0d exp ready=1 count=4", rdy, count1);
    end
    cycle(1, 0, 0, 0, 1, 3'd4, 5'd1, 5'd1, 5'd0, 6'h00, 16'h0001, 1, 32'h20210001, rdy);
    checks++;
    if ({rdy, count1, busy1} !== {1'b0, 3'd4, 1'b1}) begin
      failures++;
      $display("[TB] FAIL full_holdoff got ready=%b count=%0d busy=%b exp ready=0 count=4 busy=1",
               rdy, count1, busy1);
    end
    cycle(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, rdy);
    checks++;
    if ({done1, count1} !== {1'b1, 3'd4}) begin
      failures++;
      $display("[TB] FAIL full_finish got done=%b count=%0d exp done=1 count=4", done1, count1);
    end
  endtask

  task automatic test_priority();
    do_start(0);
    cycle(0, 0, 1, 0, 1, 3'd0, 5'd1, 5'd1, 5'd1, 6'b100101, 16'h0000, 1, 32'h00210825, rdy);
    checks++;
    if ({rdy, count0, busy0} !== {1'b0, 7'd0, 1'b1}) begin
      failures++;
      $display("[TB] FAIL start_prio got ready=%b count=%0d busy=%b exp ready=0 count=0 busy=1",
               rdy, count0, busy0);
    end
    cycle(0, 0, 0, 0, 1, 3'd0, 5'd1, 5'd1, 5'd1, 6'b100101, 16'h0000, 1, 32'h00210825, rdy);
    cycle(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, rdy);
    cycle(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, rdy);
    checks++;
    if ({busy0, done0, error0} !== 3'b000) begin
      failures++;
      $display("[TB] FAIL finish_idle got busy=%b done=%b err=%b exp 000", busy0, done0, error0);
    end
    cycle(0, 0, 0, 0, 1, 3'd1, 5'd0, 5'd2, 5'd0, 6'h00, 16'h0004, 1, 32'h8C020004, rdy);
    checks++;
    if ({rdy, count0} !== {1'b0, 7'd0}) begin
      failures++;
      $display("[TB] FAIL valid_idle got ready=%b count=%0d exp ready=0 count=0", rdy, count0);
    end
  endtask

  task automatic test_reset_mid();
    do_start(0);
    cycle(0, 0, 0, 0, 1, 3'd4, 5'd2, 5'd3, 5'd0, 6'h00, 16'h1234, 1, 32'h20431234, rdy);
    cycle(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, rdy);
    checks++;
    if ({we0, addr0, wdata0, count0, busy0, done0, error0} !== 49'd0) begin
      failures++;
      $display("[TB] FAIL reset_mid got we=%b addr=%0d data=%h count=%0d busy=%b exp all zero",
               we0, addr0, wdata0, count0, busy0);
    end
    do_start(0);
    cycle(0, 1, 0, 0, 1, 3'd4, 5'd2, 5'd3, 5'd0, 6'h00, 16'h1234, 1, 32'h20431234, rdy);
    checks++;
    if ({we0, count0, busy0} !== 9'd0) begin
      failures++;
      $display("[TB] FAIL reset_accept got we=%b count=%0d busy=%b exp zeros", we0, count0, busy0);
    end
    nop(0, 1);
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_back_to_back();
    test_illegal();
    test_full();
    test_priority();
    test_reset_mid();
    nop(0, 2);
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      failures++;
      $display("[TB] FAIL pending_writes got q0=%0d q1=%0d exp 0 0", q0.size(), q1.size());
    end
    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got timeout exp completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
